// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch PC sequencer.
// Widths, step size and the sequencer state encoding.
package pc_seq_pkg;

  localparam int PC_W  = 32;
  localparam int JT_W  = 27;
  localparam int CNT_W = 2;

  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    RUN,
    BUBBLE,
    HALTED
  } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/fetch bundle between EX/ID hazard logic and the sequencer.
// master = sequencer side, slave = pipeline side.
interface pc_sequencer_if;
  import pc_seq_pkg::*;

  logic            stall;
  logic            br_valid;
  logic            br_taken;
  logic [PC_W-1:0] br_pc4;
  logic [PC_W-1:0] br_imm;
  logic            jmp_valid;
  logic [JT_W-1:0] jmp_target;
  logic            halt;
  logic [PC_W-1:0] pc;
  logic            pc_valid;
  logic            flush;
  logic            flush_br;

  modport master (
    input  stall,
    input  br_valid,
    input  br_taken,
    input  br_pc4,
    input  br_imm,
    input  jmp_valid,
    input  jmp_target,
    input  halt,
    output pc,
    output pc_valid,
    output flush,
    output flush_br
  );

  modport slave (
    output stall,
    output br_valid,
    output br_taken,
    output br_pc4,
    output br_imm,
    output jmp_valid,
    output jmp_target,
    output halt,
    input  pc,
    input  pc_valid,
    input  flush,
    input  flush_br
  );

endinterface

// File: rtl/pc_sequencer_target_calc.sv
// Candidate next-PC values: branch target, jump target, PC+4.
// Pure combinational; all sums wrap modulo 2^32.
module pc_target_calc
  import pc_seq_pkg::*;
(
  input  logic [PC_W-1:0] br_pc4,
  input  logic [PC_W-1:0] br_imm,
  input  logic [PC_W-1:0] pc,
  input  logic [JT_W-1:0] jmp_target,
  output logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] pc_plus4
);

  // word offset: the shift drops imm[31:30]
  assign branch_target = br_pc4 + (br_imm << 2);

  assign jump_target = {pc[PC_W-1:JT_W], jmp_target};

  assign pc_plus4 = pc + PC_STEP;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: picks the next PC, inserts redirect
// bubbles, pulses flush and parks in HALTED on halt.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int REDIRECT_BUBBLES = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  pc_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] BUB_CNT =
    CNT_W'(REDIRECT_BUBBLES);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             valid_q, valid_d;
  logic             flush_q, flush_d;
  logic             fbr_q, fbr_d;

  logic [PC_W-1:0]  br_tgt;
  logic [PC_W-1:0]  jmp_tgt;
  logic [PC_W-1:0]  pc_inc;

  logic             do_halt;
  logic             do_br;
  logic             do_jmp;
  logic             do_hold;

  pc_target_calc u_calc (
    .br_pc4        (bus.br_pc4),
    .br_imm        (bus.br_imm),
    .pc            (pc_q),
    .jmp_target    (bus.jmp_target),
    .branch_target (br_tgt),
    .jump_target   (jmp_tgt),
    .pc_plus4      (pc_inc)
  );

  // one-hot RUN decision in priority order
  always_comb begin
    do_halt = bus.halt;
    do_br   = !bus.halt
            && bus.br_valid && bus.br_taken;
    do_jmp  = !bus.halt && !do_br
            && bus.jmp_valid;
    do_hold = !bus.halt && !do_br && !do_jmp
            && bus.stall;
  end

  // next-state, next-PC and pulse outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    flush_d = 1'b0;
    fbr_d   = 1'b0;
    unique case (state_q)
      RUN: begin
        unique case (1'b1)
          do_halt: begin
            state_d = HALTED;
            valid_d = 1'b0;
          end
          do_br: begin
            pc_d    = br_tgt;
            state_d = BUBBLE;
            cnt_d   = BUB_CNT;
            valid_d = 1'b0;
            flush_d = 1'b1;
            fbr_d   = 1'b1;
          end
          do_jmp: begin
            pc_d    = jmp_tgt;
            state_d = BUBBLE;
            cnt_d   = BUB_CNT;
            valid_d = 1'b0;
            flush_d = 1'b1;
          end
          do_hold: begin
            pc_d = pc_q;
          end
          default: begin
            pc_d = pc_inc;
          end
        endcase
      end
      BUBBLE: begin
        if (bus.halt) begin
          state_d = HALTED;
          valid_d = 1'b0;
        end else if (!bus.stall) begin
          if (cnt_q == CNT_ONE) begin
            state_d = RUN;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      HALTED: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      valid_q <= 1'b1;
      flush_q <= 1'b0;
      fbr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
      fbr_q   <= fbr_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_valid = valid_q;
  assign bus.flush    = flush_q;
  assign bus.flush_br = fbr_q;

endmodule
